// File: rtl/dual_issue_decode.sv
// dual_issue_decode
//   Decode/issue stage for a two-wide in-order pipe. Lane A holds the older
//   instruction and lane B the younger one. Both instructions are decoded and
//   registered into the ID/EX boundary. Two hazards are resolved by stalling:
//   - Intra-pair RAW: the pair is split and B is parked in a holding register.
//   - Load-use: a bubble is inserted in front of the consumer.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   if_valid, if_instr_*,      instruction pair and PCs from fetch
//   if_pc_*
//   id_ready                   pair consumed when if_valid && id_ready
//   ex_ready                   ID/EX can take a new pair
//   flush                      redirect; kills the outputs and any held B
//   id_*_a / id_*_b            registered decode results per lane
//
// state   | meaning
// --------+-----------------------------------------------------------------
// PAIR    | accepting pairs from fetch
// HOLD_B  | lane A of a split pair has issued; held B waits to issue alone
module dual_issue_decode #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [DATA_WIDTH-1:0] if_instr_a,
  input  logic [DATA_WIDTH-1:0] if_instr_b,
  input  logic [DATA_WIDTH-1:0] if_pc_a,
  input  logic [DATA_WIDTH-1:0] if_pc_b,
  output logic                  id_ready,
  input  logic                  ex_ready,
  input  logic                  flush,
  output logic                  id_valid_a,      id_valid_b,
  output logic [DATA_WIDTH-1:0] id_pc_a,         id_pc_b,
  output logic [REG_ADDR-1:0]   id_rd_a,         id_rd_b,
  output logic [REG_ADDR-1:0]   id_rs1_a,        id_rs1_b,
  output logic [REG_ADDR-1:0]   id_rs2_a,        id_rs2_b,
  output logic [DATA_WIDTH-1:0] id_imm_a,        id_imm_b,
  output logic [4:0]            id_alu_op_a,     id_alu_op_b,
  output logic [3:0]            id_instr_type_a, id_instr_type_b,
  output logic                  id_reg_write_a,  id_reg_write_b,
  output logic                  id_mem_read_a,   id_mem_read_b,
  output logic                  id_mem_write_a,  id_mem_write_b,
  output logic                  id_branch_a,     id_branch_b,
  output logic                  id_jump_a,       id_jump_b,
  output logic                  id_use_imm_a,    id_use_imm_b,
  output logic [3:0]            id_hazard_a,     id_hazard_b
);

  localparam logic [0:0] ST_PAIR   = 1'b0;
  localparam logic [0:0] ST_HOLD_B = 1'b1;

  localparam logic [3:0] IT_R = 4'd0, IT_I = 4'd1, IT_LOAD = 4'd2, IT_S = 4'd3,
                         IT_B = 4'd4, IT_JAL = 4'd5, IT_JALR = 4'd6, IT_LUI = 4'd7,
                         IT_AUIPC = 4'd8, IT_ECALL = 4'd9, IT_NOP = 4'd10, IT_NONE = 4'd11;

  localparam logic [3:0] HZ_A_STALL = 4'd0, HZ_B_STALL = 4'd1,
                         HZ_FROM_A = 4'd2, HZ_NONE = 4'd9;

  localparam logic [4:0] ALU_ADDR = 5'h14, ALU_CMP = 5'h15, ALU_NONE = 5'h1F;

  typedef struct packed {
    logic [REG_ADDR-1:0]   rd, rs1, rs2;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            alu_op;
    logic [3:0]            itype;
    logic reg_write, mem_read, mem_write, branch, jump, use_imm, use_rs1, use_rs2;
  } dec_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [REG_ADDR-1:0]   rd, rs1, rs2;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            alu_op;
    logic [3:0]            itype;
    logic reg_write, mem_read, mem_write, branch, jump, use_imm;
    logic [3:0]            hazard;
  } lane_t;

  function automatic dec_t decode(input logic [DATA_WIDTH-1:0] ins);
    dec_t       d;
    logic [31:0] imm32;
    logic [2:0]  f3;
    logic        f7b5;
    f3    = ins[14:12];
    f7b5  = ins[30];
    imm32 = '0;
    d     = '0;
    d.rd  = REG_ADDR'(ins[11:7]);
    d.rs1 = REG_ADDR'(ins[19:15]);
    d.rs2 = REG_ADDR'(ins[24:20]);
    d.alu_op = ALU_NONE;
    d.itype  = IT_NONE;
    case (ins[6:0])
      7'h33: begin
        d.itype = IT_R; d.reg_write = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
        case (f3)
          3'd0: d.alu_op = f7b5 ? 5'h01 : 5'h00;
          3'd1: d.alu_op = 5'h05;
          3'd2: d.alu_op = 5'h08;
          3'd3: d.alu_op = 5'h09;
          3'd4: d.alu_op = 5'h02;
          3'd5: d.alu_op = f7b5 ? 5'h07 : 5'h06;
          3'd6: d.alu_op = 5'h03;
          3'd7: d.alu_op = 5'h04;
        endcase
      end
      7'h13: begin
        d.itype = IT_I; d.reg_write = 1'b1; d.use_imm = 1'b1; d.use_rs1 = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        case (f3)
          3'd0: d.alu_op = 5'h0A;
          3'd1: d.alu_op = 5'h0E;
          3'd2: d.alu_op = 5'h12;
          3'd3: d.alu_op = 5'h13;
          3'd4: d.alu_op = 5'h0B;
          3'd5: d.alu_op = f7b5 ? 5'h11 : 5'h0F;
          3'd6: d.alu_op = 5'h0C;
          3'd7: d.alu_op = 5'h0D;
        endcase
      end
      7'h03: begin
        d.itype = IT_LOAD; d.reg_write = 1'b1; d.mem_read = 1'b1; d.use_imm = 1'b1;
        d.use_rs1 = 1'b1; d.alu_op = ALU_ADDR;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      7'h23: begin
        d.itype = IT_S; d.mem_write = 1'b1; d.use_imm = 1'b1;
        d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.alu_op = ALU_ADDR;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'h63: begin
        d.itype = IT_B; d.branch = 1'b1; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
        d.alu_op = ALU_CMP;
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'h6F: begin
        d.itype = IT_JAL; d.reg_write = 1'b1; d.jump = 1'b1; d.use_imm = 1'b1;
        d.alu_op = ALU_ADDR;
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'h67: begin
        d.itype = IT_JALR; d.reg_write = 1'b1; d.jump = 1'b1; d.use_imm = 1'b1;
        d.use_rs1 = 1'b1; d.alu_op = ALU_ADDR;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      7'h37, 7'h17: begin
        d.itype = (ins[5]) ? IT_LUI : IT_AUIPC;
        d.reg_write = 1'b1; d.use_imm = 1'b1; d.alu_op = ALU_ADDR;
        imm32 = {ins[31:12], 12'b0};
      end
      7'h73: begin
        d.itype = IT_ECALL; d.use_imm = 1'b1;
      end
      default: ;
    endcase
    if (d.rd == '0) d.reg_write = 1'b0;
    d.imm = DATA_WIDTH'($signed(imm32));
    return d;
  endfunction

  function automatic lane_t idle(input logic [3:0] hz);
    lane_t l;
    l        = '0;
    l.alu_op = ALU_NONE;
    l.itype  = IT_NOP;
    l.hazard = hz;
    return l;
  endfunction

  function automatic lane_t issue(input logic [DATA_WIDTH-1:0] pc, input dec_t d);
    lane_t l;
    l.valid     = 1'b1;
    l.pc        = pc;
    l.rd        = d.rd;
    l.rs1       = d.rs1;
    l.rs2       = d.rs2;
    l.imm       = d.imm;
    l.alu_op    = d.alu_op;
    l.itype     = d.itype;
    l.reg_write = d.reg_write;
    l.mem_read  = d.mem_read;
    l.mem_write = d.mem_write;
    l.branch    = d.branch;
    l.jump      = d.jump;
    l.use_imm   = d.use_imm;
    l.hazard    = HZ_NONE;
    return l;
  endfunction

  // A valid load sitting in the output register whose destination feeds a
  // used source of the instruction about to issue.
  function automatic logic lu_hit(input lane_t o, input dec_t d);
    return o.valid && (o.itype == IT_LOAD) && (o.rd != '0) &&
           ((d.use_rs1 && (d.rs1 == o.rd)) || (d.use_rs2 && (d.rs2 == o.rd)));
  endfunction

  lane_t                 lane_a_q, lane_b_q, lane_a_d, lane_b_d;
  logic [0:0]            state, state_d;
  logic [DATA_WIDTH-1:0] hold_instr, hold_pc;
  logic                  hold_load, load_en;
  logic                  hit_a, hit_b, hit_h, raw;
  dec_t                  dec_a, dec_b, dec_h;

  assign dec_a   = decode(if_instr_a);
  assign dec_b   = decode(if_instr_b);
  assign dec_h   = decode(hold_instr);
  assign load_en = ex_ready || !(lane_a_q.valid || lane_b_q.valid);
  assign hit_a   = lu_hit(lane_a_q, dec_a) || lu_hit(lane_b_q, dec_a);
  assign hit_b   = lu_hit(lane_a_q, dec_b) || lu_hit(lane_b_q, dec_b);
  assign hit_h   = lu_hit(lane_a_q, dec_h) || lu_hit(lane_b_q, dec_h);
  // reg_write already excludes rd == x0, so x0 never splits a pair.
  assign raw     = dec_a.reg_write &&
                   ((dec_b.use_rs1 && (dec_b.rs1 == dec_a.rd)) ||
                    (dec_b.use_rs2 && (dec_b.rs2 == dec_a.rd)));

  always_comb begin
    lane_a_d  = lane_a_q;
    lane_b_d  = lane_b_q;
    state_d   = state;
    id_ready  = 1'b0;
    hold_load = 1'b0;
    if (load_en) begin
      case (state)
        ST_PAIR: begin
          if (if_valid && (hit_a || hit_b)) begin
            lane_a_d = idle(hit_a ? HZ_A_STALL : HZ_NONE);
            lane_b_d = idle(hit_b ? HZ_B_STALL : HZ_NONE);
          end else begin
            id_ready = 1'b1;
            if (!if_valid) begin
              lane_a_d = idle(HZ_NONE);
              lane_b_d = idle(HZ_NONE);
            end else if (raw) begin
              lane_a_d  = issue(if_pc_a, dec_a);
              lane_b_d  = idle(HZ_FROM_A);
              hold_load = 1'b1;
              state_d   = ST_HOLD_B;
            end else begin
              lane_a_d = issue(if_pc_a, dec_a);
              lane_b_d = issue(if_pc_b, dec_b);
            end
          end
        end
        ST_HOLD_B: begin
          lane_a_d = idle(HZ_NONE);
          if (hit_h) begin
            lane_b_d = idle(HZ_B_STALL);
          end else begin
            lane_b_d = issue(hold_pc, dec_h);
            state_d  = ST_PAIR;
          end
        end
        default: state_d = ST_PAIR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      lane_a_q   <= idle(HZ_NONE);
      lane_b_q   <= idle(HZ_NONE);
      state      <= ST_PAIR;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      lane_a_q <= lane_a_d;
      lane_b_q <= lane_b_d;
      state    <= state_d;
      if (hold_load) begin
        hold_instr <= if_instr_b;
        hold_pc    <= if_pc_b;
      end
    end
  end

  assign id_valid_a      = lane_a_q.valid;
  assign id_pc_a         = lane_a_q.pc;
  assign id_rd_a         = lane_a_q.rd;
  assign id_rs1_a        = lane_a_q.rs1;
  assign id_rs2_a        = lane_a_q.rs2;
  assign id_imm_a        = lane_a_q.imm;
  assign id_alu_op_a     = lane_a_q.alu_op;
  assign id_instr_type_a = lane_a_q.itype;
  assign id_reg_write_a  = lane_a_q.reg_write;
  assign id_mem_read_a   = lane_a_q.mem_read;
  assign id_mem_write_a  = lane_a_q.mem_write;
  assign id_branch_a     = lane_a_q.branch;
  assign id_jump_a       = lane_a_q.jump;
  assign id_use_imm_a    = lane_a_q.use_imm;
  assign id_hazard_a     = lane_a_q.hazard;

  assign id_valid_b      = lane_b_q.valid;
  assign id_pc_b         = lane_b_q.pc;
  assign id_rd_b         = lane_b_q.rd;
  assign id_rs1_b        = lane_b_q.rs1;
  assign id_rs2_b        = lane_b_q.rs2;
  assign id_imm_b        = lane_b_q.imm;
  assign id_alu_op_b     = lane_b_q.alu_op;
  assign id_instr_type_b = lane_b_q.itype;
  assign id_reg_write_b  = lane_b_q.reg_write;
  assign id_mem_read_b   = lane_b_q.mem_read;
  assign id_mem_write_b  = lane_b_q.mem_write;
  assign id_branch_b     = lane_b_q.branch;
  assign id_jump_b       = lane_b_q.jump;
  assign id_use_imm_b    = lane_b_q.use_imm;
  assign id_hazard_b     = lane_b_q.hazard;

endmodule

// File: tb/tb_dual_issue_decode.sv
// Testbench for dual_issue_decode: expected lane contents are pushed onto a
// scoreboard queue as each pair is driven and popped when the stage output
// is due. id_ready is compared directly in the cycle it applies to.
module tb_dual_issue_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, if_valid, ex_ready, flush, id_ready;
  logic [31:0] if_instr_a, if_instr_b, if_pc_a, if_pc_b;
  logic        id_valid_a, id_valid_b;
  logic [31:0] id_pc_a, id_pc_b, id_imm_a, id_imm_b;
  logic [4:0]  id_rd_a, id_rd_b, id_rs1_a, id_rs1_b, id_rs2_a, id_rs2_b;
  logic [4:0]  id_alu_op_a, id_alu_op_b;
  logic [3:0]  id_instr_type_a, id_instr_type_b, id_hazard_a, id_hazard_b;
  logic        id_reg_write_a, id_reg_write_b, id_mem_read_a, id_mem_read_b;
  logic        id_mem_write_a, id_mem_write_b, id_branch_a, id_branch_b;
  logic        id_jump_a, id_jump_b, id_use_imm_a, id_use_imm_b;

  dual_issue_decode #(.DATA_WIDTH(32), .REG_ADDR(5)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid),
    .if_instr_a(if_instr_a), .if_instr_b(if_instr_b),
    .if_pc_a(if_pc_a), .if_pc_b(if_pc_b),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
    .id_valid_a(id_valid_a), .id_valid_b(id_valid_b),
    .id_pc_a(id_pc_a), .id_pc_b(id_pc_b),
    .id_rd_a(id_rd_a), .id_rd_b(id_rd_b),
    .id_rs1_a(id_rs1_a), .id_rs1_b(id_rs1_b),
    .id_rs2_a(id_rs2_a), .id_rs2_b(id_rs2_b),
    .id_imm_a(id_imm_a), .id_imm_b(id_imm_b),
    .id_alu_op_a(id_alu_op_a), .id_alu_op_b(id_alu_op_b),
    .id_instr_type_a(id_instr_type_a), .id_instr_type_b(id_instr_type_b),
    .id_reg_write_a(id_reg_write_a), .id_reg_write_b(id_reg_write_b),
    .id_mem_read_a(id_mem_read_a), .id_mem_read_b(id_mem_read_b),
    .id_mem_write_a(id_mem_write_a), .id_mem_write_b(id_mem_write_b),
    .id_branch_a(id_branch_a), .id_branch_b(id_branch_b),
    .id_jump_a(id_jump_a), .id_jump_b(id_jump_b),
    .id_use_imm_a(id_use_imm_a), .id_use_imm_b(id_use_imm_b),
    .id_hazard_a(id_hazard_a), .id_hazard_b(id_hazard_b)
  );

  // ctl = {reg_write, mem_read, mem_write, branch, jump, use_imm}
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [3:0]  itype;
    logic [5:0]  ctl;
    logic [3:0]  hz;
  } exp_t;

  exp_t obs_a, obs_b, e_a, e_b;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  assign obs_a = {id_valid_a, id_pc_a, id_rd_a, id_rs1_a, id_imm_a, id_alu_op_a,
                  id_instr_type_a, id_reg_write_a, id_mem_read_a, id_mem_write_a,
                  id_branch_a, id_jump_a, id_use_imm_a, id_hazard_a};
  assign obs_b = {id_valid_b, id_pc_b, id_rd_b, id_rs1_b, id_imm_b, id_alu_op_b,
                  id_instr_type_b, id_reg_write_b, id_mem_read_b, id_mem_write_b,
                  id_branch_b, id_jump_b, id_use_imm_b, id_hazard_b};

  function automatic exp_t lane(input int v, input int pc, input int rd, input int rs1,
                                input int imm, input int alu, input int it,
                                input int ctl, input int hz);
    return {(v != 0), 32'(pc), 5'(rd), 5'(rs1), 32'(imm), 5'(alu), 4'(it), 6'(ctl), 4'(hz)};
  endfunction

  function automatic exp_t idle(input int hz);
    return lane(0, 0, 0, 0, 0, 'h1F, 10, 0, hz);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    if_valid   = 1'b1;
    if_instr_a = a;
    if_instr_b = b;
    if_pc_a    = pc;
    if_pc_b    = pc + 32'd4;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;
    if_instr_a = '0; if_instr_b = '0; if_pc_a = '0; if_pc_b = '0;
    repeat (3) step();
    reset = 1'b0;
    sb.push_back(idle(9)); sb.push_back(idle(9));
    #1;
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL reset_state: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: act=%b exp=1", id_ready); end
  endtask

  task automatic test_addi_pair();
    drive_pair(32'h00500093, 32'hFFF00113, 32'h100);
    sb.push_back(lane(1, 'h100, 1, 0, 5, 'h0A, 1, 'b100001, 9));
    sb.push_back(lane(1, 'h104, 2, 0, 'hFFFFFFFF, 'h0A, 1, 'b100001, 9));
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL addi_ready: act=%b exp=1", id_ready); end
    step(); if_valid = 1'b0;
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL addi_pair: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
  endtask

  task automatic test_intra_raw();
    drive_pair(32'h003100B3, 32'h40508233, 32'h200);
    sb.push_back(lane(1, 'h200, 1, 2, 0, 'h00, 0, 'b100000, 9));
    sb.push_back(idle(2));
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL raw_ready: act=%b exp=1", id_ready); end
    step(); if_valid = 1'b0;
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL raw_split: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
    sb.push_back(idle(9));
    sb.push_back(lane(1, 'h204, 4, 1, 0, 'h01, 0, 'b100000, 9));
    #1;
    n_cmp++;
    if (id_ready !== 1'b0) begin n_err++; $display("FAIL raw_hold_ready: act=%b exp=0", id_ready); end
    step();
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL raw_held_b: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL raw_after_ready: act=%b exp=1", id_ready); end
  endtask

  task automatic test_load_use();
    drive_pair(32'h00012303, 32'h00000013, 32'h300);
    sb.push_back(lane(1, 'h300, 6, 2, 0, 'h14, 2, 'b110001, 9));
    sb.push_back(lane(1, 'h304, 0, 0, 0, 'h0A, 1, 'b000001, 9));
    step();
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL load_issue: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
    drive_pair(32'h00130393, 32'h00000013, 32'h310);
    sb.push_back(idle(0)); sb.push_back(idle(9));
    #1;
    n_cmp++;
    if (id_ready !== 1'b0) begin n_err++; $display("FAIL load_use_ready: act=%b exp=0", id_ready); end
    step();
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL load_use_bubble: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
    sb.push_back(lane(1, 'h310, 7, 6, 1, 'h0A, 1, 'b100001, 9));
    sb.push_back(lane(1, 'h314, 0, 0, 0, 'h0A, 1, 'b000001, 9));
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL bubble_after_ready: act=%b exp=1", id_ready); end
    step(); if_valid = 1'b0;
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL load_use_issue: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
  endtask

  task automatic test_ex_stall();
    exp_t xa, xb;
    xa = lane(1, 'h400, 1, 0, 5, 'h0A, 1, 'b100001, 9);
    xb = lane(1, 'h404, 2, 0, 'hFFFFFFFF, 'h0A, 1, 'b100001, 9);
    drive_pair(32'h00500093, 32'hFFF00113, 32'h400);
    sb.push_back(xa); sb.push_back(xb);
    step();
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL stall_first: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
    ex_ready = 1'b0;
    drive_pair(32'h00316093, 32'h00727193, 32'h500);
    for (int i = 0; i < 3; i++) begin
      sb.push_back(xa); sb.push_back(xb);
      #1;
      n_cmp++;
      if (id_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: act=%b exp=0", i, id_ready); end
      step();
      e_a = sb.pop_front(); e_b = sb.pop_front();
      n_cmp++;
      if ({obs_a, obs_b} !== {e_a, e_b}) begin
        n_err++; $display("FAIL stall_hold[%0d]: act_a=%h act_b=%h exp_a=%h exp_b=%h", i, obs_a, obs_b, e_a, e_b);
      end
    end
    ex_ready = 1'b1;
    sb.push_back(lane(1, 'h500, 1, 2, 3, 'h0C, 1, 'b100001, 9));
    sb.push_back(lane(1, 'h504, 3, 4, 7, 'h0D, 1, 'b100001, 9));
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: act=%b exp=1", id_ready); end
    step(); if_valid = 1'b0;
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL stall_release: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
  endtask

  task automatic test_flush_hold();
    drive_pair(32'h003100B3, 32'h40508233, 32'h600);
    sb.push_back(lane(1, 'h600, 1, 2, 0, 'h00, 0, 'b100000, 9));
    sb.push_back(idle(2));
    step(); if_valid = 1'b0;
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL flush_pre: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
    flush = 1'b1;
    sb.push_back(idle(9)); sb.push_back(idle(9));
    step(); flush = 1'b0;
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL flush_clear: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: act=%b exp=1", id_ready); end
    drive_pair(32'h00500093, 32'hFFF00113, 32'h700);
    sb.push_back(lane(1, 'h700, 1, 0, 5, 'h0A, 1, 'b100001, 9));
    sb.push_back(lane(1, 'h704, 2, 0, 'hFFFFFFFF, 'h0A, 1, 'b100001, 9));
    step(); if_valid = 1'b0;
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL flush_next: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
  endtask

  task automatic test_decode_mix();
    drive_pair(32'h000002FF, 32'h00312423, 32'h800);
    sb.push_back(lane(1, 'h800, 5, 0, 0, 'h1F, 11, 'b000000, 9));
    sb.push_back(lane(1, 'h804, 8, 2, 8, 'h14, 3, 'b001001, 9));
    step();
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL unknown_store: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
    drive_pair(32'hFFDFF0EF, 32'h00418463, 32'h900);
    sb.push_back(lane(1, 'h900, 1, 31, 'hFFFFFFFC, 'h14, 5, 'b100011, 9));
    sb.push_back(lane(1, 'h904, 8, 3, 8, 'h15, 4, 'b000100, 9));
    step(); if_valid = 1'b0;
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL jal_branch: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
  endtask

  task automatic test_back_to_back();
    drive_pair(32'h00500013, 32'h00000133, 32'hA00);
    sb.push_back(lane(1, 'hA00, 0, 0, 5, 'h0A, 1, 'b000001, 9));
    sb.push_back(lane(1, 'hA04, 2, 0, 0, 'h00, 0, 'b100000, 9));
    step();
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL x0_no_split: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
    drive_pair(32'h00500093, 32'hFFF00093, 32'hA08);
    sb.push_back(lane(1, 'hA08, 1, 0, 5, 'h0A, 1, 'b100001, 9));
    sb.push_back(lane(1, 'hA0C, 1, 0, 'hFFFFFFFF, 'h0A, 1, 'b100001, 9));
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: act=%b exp=1", id_ready); end
    step(); if_valid = 1'b0;
    e_a = sb.pop_front(); e_b = sb.pop_front();
    n_cmp++;
    if ({obs_a, obs_b} !== {e_a, e_b}) begin
      n_err++; $display("FAIL waw_pair: act_a=%h act_b=%h exp_a=%h exp_b=%h", obs_a, obs_b, e_a, e_b);
    end
  endtask

  initial begin
    test_reset();
    test_addi_pair();
    test_intra_raw();
    test_load_use();
    test_ex_stall();
    test_flush_hold();
    test_decode_mix();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
